rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART Rx deserialiser.
- Captures each received character plus its parity/stop error flags on the Rx done pulse, and presents them to the register/bus interface through a read-strobe handshake.
- Supports FIFO mode (DEPTH entries) and non-FIFO mode (single holding register), with overrun detection, flush and a fill-level threshold flag.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rx_fifo_mem.sv | 30 +++
 rtl/rx_fifo.sv | 133 +++++++++++++
 tb/tb_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path constants and entry layout helpers.
// Entry layout is {stop_err, parity_err, data}.
package uart_pkg;

  localparam int DEF_UART_DATA_W = 8;
  localparam int DEF_DEPTH_LOG2  = 4;

  localparam int ENTRY_W          = DEF_UART_DATA_W + 2;
  localparam int ENTRY_PARITY_BIT = DEF_UART_DATA_W;
  localparam int ENTRY_STOP_BIT   = DEF_UART_DATA_W + 1;

  function automatic int entry_parity_bit(int data_w);
    return data_w;
  endfunction

  function automatic int entry_stop_bit(int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Simple dual-port register array for the Rx FIFO.
// Synchronous write, registered read that holds when not enabled.
module rx_fifo_mem #(
  parameter int W  = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; old data is returned on same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_fifo.sv
// Receive buffer between the UART Rx deserialiser and the bus side.
// FIFO or single holding-register mode, overrun, flush, threshold.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int MAX_UART_DATA_W = DEF_UART_DATA_W,
  parameter int DEPTH_LOG2      = DEF_DEPTH_LOG2,
  parameter int ENTRY_W         = MAX_UART_DATA_W + 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_done_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic                       fifo_en_i,
  input  logic                       flush_i,
  input  logic                       rd_en_i,
  input  logic                       clr_overrun_i,
  input  logic [DEPTH_LOG2-1:0]      thresh_i,
  output logic [MAX_UART_DATA_W-1:0] rd_data_o,
  output logic                       rd_parity_err_o,
  output logic                       rd_stop_err_o,
  output logic                       rd_valid_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [DEPTH_LOG2:0]        count_o,
  output logic                       overrun_o,
  output logic                       thresh_o
);

  localparam int CW  = DEPTH_LOG2 + 1;
  localparam int PB  = entry_parity_bit(MAX_UART_DATA_W);
  localparam int SB  = entry_stop_bit(MAX_UART_DATA_W);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_en_q;
  logic                  overrun;
  logic                  rd_valid;

  logic                  flush_evt;
  logic                  full;
  logic                  empty;
  logic                  do_rd;
  logic                  wr_req;
  logic                  drop;
  logic                  inc;
  logic                  mem_we;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;

  // Decode flush, capacity and the accepted read/write for this cycle.
  always_comb begin
    flush_evt = flush_i | (fifo_en_i != fifo_en_q);
    empty     = (count == '0);
    full      = fifo_en_i ? (count == DEPTH_CNT) : (count != '0);
    do_rd     = rd_en_i & ~empty & ~flush_evt;
    wr_req    = rx_done_i & ~flush_evt;
    drop      = wr_req & full & ~do_rd;
    inc       = wr_req & ~drop;
    mem_we    = fifo_en_i ? inc : wr_req;
    wr_entry  = '0;
    wr_entry[MAX_UART_DATA_W-1:0] = rx_data_i;
    wr_entry[PB] = rx_parity_err_i;
    wr_entry[SB] = rx_stop_err_i;
  end

  // Pointers, fill count, mode tracking and read-valid pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_en_q <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en_i;
      rd_valid  <= do_rd;
      if (flush_evt) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (fifo_en_i && inc)   wr_ptr <= wr_ptr + 1'b1;
        if (fifo_en_i && do_rd) rd_ptr <= rd_ptr + 1'b1;
        unique case ({inc, do_rd})
          2'b10:   count <= count + ONE_CNT;
          2'b01:   count <= count - ONE_CNT;
          default: count <= count;
        endcase
      end
    end
  end

  // Sticky overrun; a same-cycle drop beats the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clr_overrun_i) overrun <= 1'b0;
  end

  rx_fifo_mem #(
    .W  (ENTRY_W),
    .AW (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (do_rd),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Output mapping and threshold compare.
  always_comb begin
    rd_data_o       = rd_entry[MAX_UART_DATA_W-1:0];
    rd_parity_err_o = rd_entry[PB];
    rd_stop_err_o   = rd_entry[SB];
    rd_valid_o      = rd_valid;
    empty_o         = empty;
    full_o          = full;
    count_o         = count;
    overrun_o       = overrun;
    thresh_o        = (thresh_i != '0) && (count >= {1'b0, thresh_i});
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo.
// Inputs change 1ns after the rising edge; outputs checked there too.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_par;
  logic       rx_stop;
  logic       fifo_en;
  logic       flush;
  logic       rd_en;
  logic       clr_ovr;
  logic [3:0] thresh;
  logic [7:0] rd_data;
  logic       rd_par;
  logic       rd_stop;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       thresh_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_fifo dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_done_i       (rx_done),
    .rx_data_i       (rx_data),
    .rx_parity_err_i (rx_par),
    .rx_stop_err_i   (rx_stop),
    .fifo_en_i       (fifo_en),
    .flush_i         (flush),
    .rd_en_i         (rd_en),
    .clr_overrun_i   (clr_ovr),
    .thresh_i        (thresh),
    .rd_data_o       (rd_data),
    .rd_parity_err_o (rd_par),
    .rd_stop_err_o   (rd_stop),
    .rd_valid_o      (rd_valid),
    .empty_o         (empty),
    .full_o          (full),
    .count_o         (count),
    .overrun_o       (overrun),
    .thresh_o        (thresh_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic p, input logic s);
    rx_done = 1'b1;
    rx_data = d;
    rx_par  = p;
    rx_stop = s;
    tick();
    rx_done = 1'b0;
    rx_par  = 1'b0;
    rx_stop = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_done = 0; rx_data = 0; rx_par = 0; rx_stop = 0;
    fifo_en = 1'b1; flush = 0; rd_en = 0; clr_ovr = 0; thresh = 0;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_thr", 32'(thresh_q), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", {22'd0, rd_stop, rd_par, rd_data}, 0);
    rst = 1'b0;
    tick();
    tick();

    // basic three-character path
    wr(8'h41, 0, 0);
    wr(8'h42, 0, 0);
    wr(8'h43, 0, 0);
    chk("t1_count3", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      rd();
      chk("t1_valid", 32'(rd_valid), 1);
      chk("t1_data", 32'(rd_data), 32'h41 + i);
      chk("t1_count", 32'(count), 2 - i);
      tick();
      chk("t1_pulse", 32'(rd_valid), 0);
    end
    chk("t1_empty", 32'(empty), 1);

    // fill, overflow, drain
    for (int i = 0; i < 17; i++) begin
      wr(8'(i), 0, 0);
      if (i == 14) chk("t2_nfull15", 32'(full), 0);
      if (i == 15) begin
        chk("t2_full", 32'(full), 1);
        chk("t2_ovr0", 32'(overrun), 0);
      end
    end
    chk("t2_ovr", 32'(overrun), 1);
    chk("t2_cnt16", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("t2_data", 32'(rd_data), i);
    end
    chk("t2_empty", 32'(empty), 1);
    rd();
    chk("t2_emptyrd", 32'(rd_valid), 0);
    chk("t2_hold", 32'(rd_data), 32'h0F);
    chk("t2_ovrkeep", 32'(overrun), 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t2_clr", 32'(overrun), 0);

    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 0, 0);
    rd_en = 1'b1;
    wr(8'hAA, 0, 0);
    rd_en = 1'b0;
    chk("t3_data", 32'(rd_data), 32'h80);
    chk("t3_cnt", 32'(count), 16);
    chk("t3_ovr", 32'(overrun), 0);
    for (int i = 1; i < 16; i++) begin
      rd();
      chk("t3_drain", 32'(rd_data), 32'h80 + i);
    end
    rd();
    chk("t3_last", 32'(rd_data), 32'hAA);
    chk("t3_empty", 32'(empty), 1);

    // single holding register mode
    fifo_en = 1'b0;
    tick();
    tick();
    wr(8'h11, 0, 0);
    chk("t4_cnt1", 32'(count), 1);
    chk("t4_full", 32'(full), 1);
    wr(8'h22, 0, 0);
    chk("t4_ovr", 32'(overrun), 1);
    chk("t4_cnt", 32'(count), 1);
    rd();
    chk("t4_data", 32'(rd_data), 32'h22);
    chk("t4_empty", 32'(empty), 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // error flags and threshold
    fifo_en = 1'b1;
    tick();
    tick();
    thresh = 4'd1;
    #1;
    chk("t5_thr0", 32'(thresh_q), 0);
    wr(8'h5A, 1, 0);
    chk("t5_thr1", 32'(thresh_q), 1);
    wr(8'hC3, 0, 1);
    rd();
    chk("t5_d", {22'd0, rd_stop, rd_par, rd_data}, 32'h15A);
    rd();
    chk("t5_e", {22'd0, rd_stop, rd_par, rd_data}, 32'h2C3);
    chk("t5_thr_e", 32'(thresh_q), 0);
    thresh = 4'd3;
    wr(8'h01, 0, 0);
    wr(8'h02, 0, 0);
    chk("t5_thr2", 32'(thresh_q), 0);
    wr(8'h03, 0, 0);
    chk("t5_thr3", 32'(thresh_q), 1);
    thresh = 4'd0;
    #1;
    chk("t5_thrz", 32'(thresh_q), 0);

    // mode toggle flush with five entries
    wr(8'h04, 0, 0);
    wr(8'h05, 0, 0);
    chk("t6_cnt5", 32'(count), 5);
    fifo_en = 1'b0;
    tick();
    chk("t6_cnt", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    fifo_en = 1'b1;
    tick();
    tick();

    // explicit flush with a same-cycle write
    wr(8'h06, 0, 0);
    flush = 1'b1;
    wr(8'h07, 0, 0);
    flush = 1'b0;
    chk("t7_flush", 32'(count), 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 17; i++) wr(8'h30 + 8'(i), 0, 0);
    rd();
    chk("t8_pre", 32'(rd_data), 32'h30);
    chk("t8_preovr", 32'(overrun), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t8_cnt", 32'(count), 0);
    chk("t8_empty", 32'(empty), 1);
    chk("t8_ovr", 32'(overrun), 0);
    chk("t8_data", 32'(rd_data), 0);
    chk("t8_valid", 32'(rd_valid), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
